// File: rtl/head_burn_recorder.sv
// rtl/head_burn_recorder.sv - Turns thermal-head burns into print-line records.
// Captures the dot snapshot, times the burn, popcounts in chunks and offers a record.
module head_burn_recorder #(
  parameter int HEAD_WIDTH     = 384,
  parameter int CHUNK_WIDTH    = 32,
  parameter int BURN_CNT_WIDTH = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              head_active,
  input  logic [HEAD_WIDTH-1:0]             head_active_dots,
  input  logic                              record_ready,
  output logic                              record_valid,
  output logic [HEAD_WIDTH-1:0]             record_dots,
  output logic [$clog2(HEAD_WIDTH+1)-1:0]   record_dot_count,
  output logic [BURN_CNT_WIDTH-1:0]         record_burn_cycles,
  output logic                              record_saturated,
  output logic                              record_dots_changed,
  output logic [7:0]                        overflow_count,
  output logic                              busy
);

  localparam int N     = HEAD_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = $clog2(HEAD_WIDTH + 1);
  localparam int PC_W  = $clog2(CHUNK_WIDTH + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BURN, COUNT} state_t;

  state_t                    state_q, state_d;
  logic                      head_prev_q;
  logic [HEAD_WIDTH-1:0]     snap_q, snap_d;
  logic [BURN_CNT_WIDTH-1:0] burn_q, burn_d;
  logic                      sat_q, sat_d;
  logic                      changed_q, changed_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          acc_q, acc_d;

  logic                      rec_valid_q, rec_valid_d;
  logic [HEAD_WIDTH-1:0]     rec_dots_q, rec_dots_d;
  logic [CNT_W-1:0]          rec_count_q, rec_count_d;
  logic [BURN_CNT_WIDTH-1:0] rec_burn_q, rec_burn_d;
  logic                      rec_sat_q, rec_sat_d;
  logic                      rec_changed_q, rec_changed_d;
  logic [7:0]                ovf_q, ovf_d;

  logic                      rise;
  logic [CHUNK_WIDTH-1:0]    chunk;
  logic [PC_W-1:0]           chunk_pop;
  logic [CNT_W-1:0]          acc_sum;
  logic                      complete, drop, miss;
  logic [8:0]                ovf_sum;

  assign rise    = head_active & ~head_prev_q;
  assign chunk   = snap_q[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign acc_sum = acc_q + CNT_W'(chunk_pop);

  always_comb begin
    chunk_pop = '0;
    for (int b = 0; b < CHUNK_WIDTH; b++) begin
      chunk_pop = chunk_pop + PC_W'(chunk[b]);
    end
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    burn_d        = burn_q;
    sat_d         = sat_q;
    changed_d     = changed_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    rec_valid_d   = rec_valid_q;
    rec_dots_d    = rec_dots_q;
    rec_count_d   = rec_count_q;
    rec_burn_d    = rec_burn_q;
    rec_sat_d     = rec_sat_q;
    rec_changed_d = rec_changed_q;
    complete      = 1'b0;
    miss          = 1'b0;
    drop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          snap_d    = head_active_dots;
          burn_d    = BURN_CNT_WIDTH'(1);
          sat_d     = (BURN_CNT_WIDTH == 1);
          changed_d = 1'b0;
          state_d   = BURN;
        end
      end
      BURN: begin
        if (head_active) begin
          if (burn_q != '1) begin
            burn_d = burn_q + 1'b1;
          end
          sat_d = sat_q | (burn_d == '1);
          if (head_active_dots != snap_q) begin
            changed_d = 1'b1;
          end
        end else begin
          idx_d   = '0;
          acc_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_sum;
        // A burn starting before the count finishes cannot be captured.
        miss  = rise;
        if (idx_q == LAST_IDX) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rec_valid_q && record_ready) begin
      rec_valid_d = 1'b0;
    end
    if (complete) begin
      if (!rec_valid_q || record_ready) begin
        rec_valid_d   = 1'b1;
        rec_dots_d    = snap_q;
        rec_count_d   = acc_sum;
        rec_burn_d    = burn_q;
        rec_sat_d     = sat_q;
        rec_changed_d = changed_q;
      end else begin
        drop = 1'b1;
      end
    end

    ovf_sum = {1'b0, ovf_q} + {8'd0, drop} + {8'd0, miss};
    ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      head_prev_q   <= 1'b0;
      snap_q        <= '0;
      burn_q        <= '0;
      sat_q         <= 1'b0;
      changed_q     <= 1'b0;
      idx_q         <= '0;
      acc_q         <= '0;
      rec_valid_q   <= 1'b0;
      rec_dots_q    <= '0;
      rec_count_q   <= '0;
      rec_burn_q    <= '0;
      rec_sat_q     <= 1'b0;
      rec_changed_q <= 1'b0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      head_prev_q   <= head_active;
      snap_q        <= snap_d;
      burn_q        <= burn_d;
      sat_q         <= sat_d;
      changed_q     <= changed_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      rec_valid_q   <= rec_valid_d;
      rec_dots_q    <= rec_dots_d;
      rec_count_q   <= rec_count_d;
      rec_burn_q    <= rec_burn_d;
      rec_sat_q     <= rec_sat_d;
      rec_changed_q <= rec_changed_d;
      ovf_q         <= ovf_d;
    end
  end

  assign record_valid        = rec_valid_q;
  assign record_dots         = rec_dots_q;
  assign record_dot_count    = rec_count_q;
  assign record_burn_cycles  = rec_burn_q;
  assign record_saturated    = rec_sat_q;
  assign record_dots_changed = rec_changed_q;
  assign overflow_count      = ovf_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: doc/head_burn_recorder.md
# head_burn_recorder

Sits directly downstream of the thermal head model and turns its strobed dot output into discrete print-line records. Each burn is one contiguous period of `head_active` high. For each burn the block captures the dot pattern, measures the burn duration in `clk` cycles and counts the energised dots with a multi-cycle chunked popcount. It then presents the result as one record on a valid/ready interface to the analyser's capture/host path. Records that cannot be delivered are dropped and counted, never silently lost.

## Interface
Parameters:
- `HEAD_WIDTH`, 384: number of head dots. Must be a multiple of `CHUNK_WIDTH`.
- `CHUNK_WIDTH`, 32: dots summed per popcount cycle. N = `HEAD_WIDTH`/`CHUNK_WIDTH`.
- `BURN_CNT_WIDTH`, 24: width of the burn duration counter.

Ports (reset `reset`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous active-low reset
- `head_active`  in  1  registered head strobe (DST) from thermal head
- `head_active_dots`  in  HEAD_WIDTH  registered dot pattern from thermal head
- `record_ready`  in  1  consumer accepts record
- `record_valid`  out  1  record available
- `record_dots`  out  HEAD_WIDTH  dot pattern captured at burn start
- `record_dot_count`  out  $clog2(HEAD_WIDTH+1)  number of set bits in `record_dots`
- `record_burn_cycles`  out  BURN_CNT_WIDTH  cycles `head_active` was high
- `record_saturated`  out  1  burn counter saturated
- `record_dots_changed`  out  1  dot input differed from the snapshot during the burn
- `overflow_count`  out  8  dropped/missed burns, saturating at 255
- `busy`  out  1  FSM not in IDLE

## Operation
- Edge detect: `head_prev` register. Rise = `head_active & !head_prev`.
- FSM states IDLE, BURN, COUNT.
- IDLE, on rise:
  - snapshot `head_active_dots`
  - burn_cnt=1, changed=0
  - go to BURN
  - If `head_active` is already high with no rise (e.g. after reset or a missed burn), remain in IDLE.
- BURN, while `head_active`=1:
  - burn_cnt increments, saturating at all-ones; saturated flag set on reaching all-ones.
  - changed is set if `head_active_dots` != snapshot.
- BURN, on the first cycle `head_active`=0: chunk index=0, accumulator=0, go to COUNT.
- COUNT:
  - Each cycle adds the popcount of snapshot chunk i (bits i*CHUNK_WIDTH +: CHUNK_WIDTH) to the accumulator. Chunk 0 = LSBs.
  - After chunk N-1, the record is offered to the output slot, then the FSM goes to IDLE.
- Output slot:
  - The slot is free if `record_valid`=0, or if `record_valid & record_ready` in the same cycle.
  - If free: load all `record_*` fields and set `record_valid`.
  - If not free: discard the record and increment `overflow_count`.
- Rise while in COUNT: that burn is not recorded and `overflow_count` increments. After COUNT the FSM returns to IDLE and waits for the next rise.
- If a drop and a missed rise occur in the same cycle, `overflow_count` increments by 2 (saturating).
- `record_dot_count` equals the popcount of `record_dots`, range 0..HEAD_WIDTH.
- `record_*` outputs are held stable while `record_valid`=1. `record_valid` clears on `record_valid & record_ready` unless a new record loads in the same cycle.

## Timing
- Reset value of all outputs and state is 0, FSM in IDLE. Reset is asynchronous and can occur at any point, including mid-BURN or mid-COUNT. It aborts the operation, clears a pending record and clears `overflow_count`.
- Rise sampled at edge E: snapshot taken from `head_active_dots` sampled at E.
- burn_cnt equals the number of edges that sampled `head_active`=1 within the burn.
- Latency from the first edge sampling `head_active`=0 (edge F):
  - COUNT spans edges F+1..F+N.
  - `record_valid`=1 after edge F+N.
  - Default latency: 12 cycles.
- Minimum burn-to-burn spacing without a miss: the next rise must be sampled after COUNT ends, i.e. at edge F+N+1 or later.
- `busy`=1 from the edge after the rise through the last COUNT cycle.
- Handshake: the transfer occurs on the edge where `record_valid & record_ready`=1. `record_ready` may be held high permanently. `record_valid` does not depend combinationally on `record_ready`.

## Test plan
- Single burn: dots=0x...0005_0001 (bits 0, 16, 18), `head_active` high 5 cycles, `record_ready`=1. Expect one record: count=3, burn=5, saturated=0, changed=0, `record_valid` 12 cycles after `head_active` falls.
- All dots set, 1-cycle burn: expect count=384, burn=1. Then all-zero dots: expect count=0.
- Backpressure: `record_ready`=0, three burns spaced ≥14 cycles apart. Expect the first record held unchanged and `overflow_count`=2. Raise ready: the first record transfers and `record_valid` drops.
- Completion in the same cycle as acceptance: expect the new record loaded, `record_valid` stays 1 and `overflow_count` unchanged.
- Edge cases:
  - `BURN_CNT_WIDTH`=4 with a 20-cycle burn: expect burn=15, saturated=1.
  - Dots changed mid-burn: expect changed=1 and `record_dots` equal to the snapshot taken at burn start.
  - Rise during COUNT: expect `overflow_count`+1 and no record for that burn.
- Reset asserted mid-COUNT with a record pending: expect all outputs 0 immediately. After release, the next burn records normally.
